// File: rtl/circular_shift_pkg.sv
// Shared types and helpers for the pipelined variable circular shifter.
package circular_shift_pkg;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   // Source bit index feeding output bit i of a w-bit rotate by the constant s.
   function automatic int unsigned rot_src(input int unsigned i,
                                           input int unsigned w,
                                           input int unsigned s,
                                           input dir_e        dir);
      if (dir == DIR_LEFT)
         return (i + w - (s % w)) % w;
      else
         return (i + s) % w;
   endfunction

endpackage

// File: rtl/circular_shift_stage.sv
// One rotate-by-2^K pipeline stage with its own valid/ready register.
module circular_shift_stage
   import circular_shift_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned SW = 3,
   parameter int unsigned K  = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arg_vld,
   output logic          arg_rdy,
   input  logic [N-1:0]  arg_data,
   input  logic [SW-1:0] arg_amt,
   input  logic          arg_dir,
   output logic          res_vld,
   input  logic          res_rdy,
   output logic [N-1:0]  res_data,
   output logic [SW-1:0] res_amt,
   output logic          res_dir
);

   logic [N-1:0] rot_l;
   logic [N-1:0] rot_r;
   logic [N-1:0] nxt;

   for (genvar i = 0; i < N; i++) begin : g_bit
      localparam int unsigned SL = rot_src(i, N, 2**K, DIR_LEFT);
      localparam int unsigned SR = rot_src(i, N, 2**K, DIR_RIGHT);
      assign rot_l[i] = arg_data[SL];
      assign rot_r[i] = arg_data[SR];
   end

   always_comb begin
      nxt = arg_data;
      if (arg_amt[K])
         nxt = (dir_e'(arg_dir) == DIR_RIGHT) ? rot_r : rot_l;
   end

   // Load when empty or when the current entry leaves this cycle.
   assign arg_rdy = !res_vld || res_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         res_vld  <= 1'b0;
         res_data <= '0;
         res_amt  <= '0;
         res_dir  <= DIR_LEFT;
      end else if (arg_rdy) begin
         res_vld <= arg_vld;
         if (arg_vld) begin
            res_data <= nxt;
            res_amt  <= arg_amt;
            res_dir  <= arg_dir;
         end
      end
   end

endmodule

// File: rtl/circular_shift_variable_pipelined.sv
// Pipelined variable circular shifter, one stage per amount bit.
// Define CIRCULAR_SHIFT_OUT_REG_EN to add a registered output stage.
module circular_shift_variable_pipelined
   import circular_shift_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arg_vld,
   output logic          arg_rdy,
   input  logic [N-1:0]  arg_data,
   input  logic [SW-1:0] arg_amt,
   input  logic          arg_dir,
   output logic          res_vld,
   input  logic          res_rdy,
   output logic [N-1:0]  res_data
);

   logic [SW:0]   vld;
   logic [SW:0]   rdy;
   logic [SW:0]   dir;
   logic [N-1:0]  data [SW+1];
   logic [SW-1:0] amt  [SW+1];

   assign vld[0]  = arg_vld;
   assign arg_rdy = rdy[0];
   assign data[0] = arg_data;
   assign amt[0]  = arg_amt;
   assign dir[0]  = arg_dir;

   for (genvar k = 0; k < SW; k++) begin : g_stage
      circular_shift_stage #(
         .N  (N),
         .SW (SW),
         .K  (k)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .arg_vld  (vld[k]),
         .arg_rdy  (rdy[k]),
         .arg_data (data[k]),
         .arg_amt  (amt[k]),
         .arg_dir  (dir[k]),
         .res_vld  (vld[k+1]),
         .res_rdy  (rdy[k+1]),
         .res_data (data[k+1]),
         .res_amt  (amt[k+1]),
         .res_dir  (dir[k+1])
      );
   end

`ifdef CIRCULAR_SHIFT_OUT_REG_EN
   logic         o_vld;
   logic [N-1:0] o_data;

   assign rdy[SW] = !o_vld || res_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_vld  <= 1'b0;
         o_data <= '0;
      end else if (rdy[SW]) begin
         o_vld <= vld[SW];
         if (vld[SW])
            o_data <= data[SW];
      end
   end

   assign res_vld  = o_vld;
   assign res_data = o_data;
`else
   assign rdy[SW]  = res_rdy;
   assign res_vld  = vld[SW];
   assign res_data = data[SW];
`endif

endmodule

// File: tb/tb_circular_shift_variable_pipelined.sv
// Directed self-checking bench for circular_shift_variable_pipelined (N=8).
module tb_circular_shift_variable_pipelined;

   logic       clk = 1'b0;
   logic       rst;
   logic       arg_vld;
   logic       arg_rdy;
   logic [7:0] arg_data;
   logic [2:0] arg_amt;
   logic       arg_dir;
   logic       res_vld;
   logic       res_rdy;
   logic [7:0] res_data;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] data;
      logic [2:0] amt;
      logic       dir;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [8];

   circular_shift_variable_pipelined #(.N(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .arg_vld  (arg_vld),
      .arg_rdy  (arg_rdy),
      .arg_data (arg_data),
      .arg_amt  (arg_amt),
      .arg_dir  (arg_dir),
      .res_vld  (res_vld),
      .res_rdy  (res_rdy),
      .res_data (res_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int idx);
      arg_vld  = 1'b1;
      arg_data = tbl[idx].data;
      arg_amt  = tbl[idx].amt;
      arg_dir  = tbl[idx].dir;
   endtask

   initial begin
      logic       acc;
      logic       out;
      logic [7:0] seen;
      int         got;
      int         sent;
      int         streak;

      tbl[0] = '{8'hB4, 3'd3, 1'b1, 8'h96};
      tbl[1] = '{8'h01, 3'd1, 1'b1, 8'h80};
      tbl[2] = '{8'hB4, 3'd0, 1'b0, 8'hB4};
      tbl[3] = '{8'hB4, 3'd0, 1'b1, 8'hB4};
      tbl[4] = '{8'h81, 3'd1, 1'b0, 8'h03};
      tbl[5] = '{8'h81, 3'd1, 1'b1, 8'hC0};
      tbl[6] = '{8'hF0, 3'd4, 1'b0, 8'h0F};
      tbl[7] = '{8'h3C, 3'd7, 1'b0, 8'h1E};

      rst = 1'b1; arg_vld = 1'b0; arg_data = '0; arg_amt = '0; arg_dir = 1'b0; res_rdy = 1'b1;
      step(); step();
      chk("reset_res_vld", 32'(res_vld), 32'd0);
      chk("reset_res_data", 32'(res_data), 32'd0);
      rst = 1'b0;
      step();
      chk("arg_rdy_after_reset", 32'(arg_rdy), 32'd1);

      // Single item latency: B4 left by 3
      arg_vld = 1'b1; arg_data = 8'hB4; arg_amt = 3'd3; arg_dir = 1'b0;
      step();
      arg_vld = 1'b0;
      chk("lat_e1_vld", 32'(res_vld), 32'd0);
      step();
      chk("lat_e2_vld", 32'(res_vld), 32'd0);
      step();
      chk("lat_e3_vld", 32'(res_vld), 32'd1);
      chk("lat_e3_data", 32'(res_data), 32'hA5);
      step();
      chk("lat_drain_vld", 32'(res_vld), 32'd0);

      // Back-to-back table stream with res_rdy held high
      streak = 0;
      for (int c = 0; c < 11; c++) begin
         if (c < 8) begin
            drive(c);
            #1;
            chk($sformatf("stream_arg_rdy_%0d", c), 32'(arg_rdy), 32'd1);
         end else begin
            arg_vld = 1'b0;
         end
         step();
         if (c >= 2 && c < 10) begin
            chk($sformatf("stream_vld_%0d", c - 2), 32'(res_vld), 32'd1);
            chk($sformatf("stream_data_%0d", c - 2), 32'(res_data), 32'(tbl[c-2].exp));
            if (res_vld) streak++;
         end else begin
            chk($sformatf("stream_idle_vld_%0d", c), 32'(res_vld), 32'd0);
         end
      end
      chk("stream_consecutive", 32'(streak), 32'd8);

      // Backpressure: fill with res_rdy low, then release
      res_rdy = 1'b0;
      sent = 0;
      for (int c = 0; c < 3; c++) begin
         drive(sent);
         #1;
         if (arg_rdy) sent++;
         step();
      end
      chk("stall_accepted", 32'(sent), 32'd3);
      drive(sent);
      #1;
      chk("stall_arg_rdy_low", 32'(arg_rdy), 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("stall_hold_vld_%0d", c), 32'(res_vld), 32'd1);
         chk($sformatf("stall_hold_data_%0d", c), 32'(res_data), 32'(tbl[0].exp));
      end
      res_rdy = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         #1;
         acc  = arg_vld && arg_rdy;
         out  = res_vld && res_rdy;
         seen = res_data;
         step();
         if (out) begin
            chk($sformatf("drain_data_%0d", got), 32'(seen), 32'(tbl[got].exp));
            got++;
         end
         if (acc) begin
            sent++;
            if (sent < 4) drive(sent);
            else arg_vld = 1'b0;
         end
      end
      chk("drain_count", 32'(got), 32'd4);
      step();
      chk("drain_empty_vld", 32'(res_vld), 32'd0);

      // Reset with two items in flight
      drive(4);
      step();
      drive(5);
      step();
      arg_vld = 1'b0;
      rst = 1'b1;
      step();
      chk("midrst_vld", 32'(res_vld), 32'd0);
      chk("midrst_data", 32'(res_data), 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_arg_rdy", 32'(arg_rdy), 32'd1);
      got = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (res_vld) got++;
      end
      chk("midrst_no_stale", 32'(got), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
